hbridge_drive: RTL

HBRIDGE_DRIVE -- requirements
Module: hbridge_drive

---
 rtl/hb_pkg.sv | 29 ++
 rtl/hb_channel.sv | 123 ++++++++++++
 rtl/hbridge_drive.sv | 79 +++++++
 3 files changed

// File: rtl/hb_pkg.sv
// Shared types for the dual H-bridge driver.
//   dir_t      : decoded direction command (STOP, FWD, REV)
//   ch_state_t : per-channel state (IDLE, DEAD, RUN_FWD, RUN_REV)
//   decode_cmd : maps a raw {motor1,motor2} command pair onto dir_t
package hb_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEAD    = 2'd1,
    RUN_FWD = 2'd2,
    RUN_REV = 2'd3
  } ch_state_t;

  // 2'b11 would turn on both legs of the bridge, so it is folded into STOP.
  function automatic dir_t decode_cmd(input logic [1:0] cmd);
    case (cmd)
      2'b10:   return FWD;
      2'b01:   return REV;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/hb_channel.sv
// One H-bridge channel: command decode, direction FSM, dead-time counter
// and soft-start duty register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_i        : registered {motor1,motor2} command
//   pwm_cnt_i    : shared free-running PWM counter
//   ramp_tick_i  : one-cycle pulse from the shared ramp prescaler
//   drv_o        : gate pair {leg1,leg2}; never 2'b11
//   busy_o       : channel is in dead time or still ramping
module hb_channel
  import hb_pkg::*;
#(
  parameter int PWM_TOP     = 999,
  parameter int DEAD_CYCLES = 500,
  parameter int RAMP_INC    = 10,
  parameter int CW          = $clog2(PWM_TOP + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd_i,
  input  logic [CW-1:0] pwm_cnt_i,
  input  logic          ramp_tick_i,
  output logic [1:0]    drv_o,
  output logic          busy_o
);

  localparam int            DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] DUTY_FULL = CW'(PWM_TOP + 1);
  // Any duty at or above this would pass 100 % after one more increment.
  localparam int            SAT_AT    = PWM_TOP + 1 - RAMP_INC;

  ch_state_t     state_q, state_d;
  dir_t          pend_q, pend_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [CW-1:0] duty_q, duty_d;

  dir_t          dir;
  dir_t          own_dir;
  logic          pwm_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= STOP;
      dead_cnt_q <= '0;
      duty_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      dead_cnt_q <= dead_cnt_d;
      duty_q     <= duty_d;
    end
  end

  always_comb begin
    dir        = decode_cmd(cmd_i);
    own_dir    = (state_q == RUN_FWD) ? FWD : REV;
    state_d    = state_q;
    pend_d     = pend_q;
    dead_cnt_d = dead_cnt_q;
    duty_d     = duty_q;

    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (dir == FWD)      state_d = RUN_FWD;
        else if (dir == REV) state_d = RUN_REV;
      end

      DEAD: begin
        if (dir == STOP) begin
          state_d    = IDLE;
          dead_cnt_d = '0;
          duty_d     = '0;
        end else begin
          // Direction may flip while waiting; the count keeps running.
          pend_d = dir;
          if (dead_cnt_q == DEAD_LAST) begin
            state_d    = (pend_d == FWD) ? RUN_FWD : RUN_REV;
            dead_cnt_d = '0;
            duty_d     = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
      end

      RUN_FWD, RUN_REV: begin
        if (dir == STOP) begin
          state_d = IDLE;
          duty_d  = '0;
        end else if (dir != own_dir) begin
          state_d    = DEAD;
          pend_d     = dir;
          dead_cnt_d = '0;
          duty_d     = '0;
        end else if (ramp_tick_i) begin
          duty_d = (int'(duty_q) >= SAT_AT) ? DUTY_FULL : duty_q + CW'(RAMP_INC);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from the state register so that entering IDLE or
  // DEAD (or reset) blanks the bridge in the very same cycle.
  assign pwm_on = (pwm_cnt_i < duty_q);

  always_comb begin
    drv_o = 2'b00;
    case (state_q)
      RUN_FWD: drv_o = {pwm_on, 1'b0};
      RUN_REV: drv_o = {1'b0, pwm_on};
      default: drv_o = 2'b00;
    endcase
  end

  assign busy_o = (state_q == DEAD) ||
                  (((state_q == RUN_FWD) || (state_q == RUN_REV)) && (duty_q != DUTY_FULL));

endmodule

// File: rtl/hbridge_drive.sv
// Dual H-bridge driver with dead-time insertion on reversal and soft-start
// PWM ramp. Both channels share one PWM counter and one ramp prescaler.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   left_cmd, right_cmd  : {motor1,motor2} commands (10 FWD, 01 REV, else STOP)
//   left_drv, right_drv  : H-bridge gate pairs
//   busy                 : either channel in dead time or ramping
module hbridge_drive
  import hb_pkg::*;
#(
  parameter int PWM_TOP     = 999,
  parameter int DEAD_CYCLES = 500,
  parameter int RAMP_DIV    = 50000,
  parameter int RAMP_INC    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] left_cmd,
  input  logic [1:0] right_cmd,
  output logic [1:0] left_drv,
  output logic [1:0] right_drv,
  output logic       busy
);

  localparam int            CW       = $clog2(PWM_TOP + 2);
  localparam int            PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] PWM_LAST = CW'(PWM_TOP);
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [1:0]    cmd_q [2];
  logic [1:0]    drv   [2];
  logic [1:0]    ch_busy;
  logic [CW-1:0] pwm_q, pwm_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ramp_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q[0] <= 2'b00;
      cmd_q[1] <= 2'b00;
      pwm_q    <= '0;
      pre_q    <= '0;
    end else begin
      cmd_q[0] <= left_cmd;
      cmd_q[1] <= right_cmd;
      pwm_q    <= pwm_d;
      pre_q    <= pre_d;
    end
  end

  always_comb begin
    pwm_d     = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    ramp_tick = (pre_q == PRE_LAST);
  end

  // Channel 0 is the left motor, channel 1 the right motor.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    hb_channel #(
      .PWM_TOP     (PWM_TOP),
      .DEAD_CYCLES (DEAD_CYCLES),
      .RAMP_INC    (RAMP_INC),
      .CW          (CW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_i       (cmd_q[gi]),
      .pwm_cnt_i   (pwm_q),
      .ramp_tick_i (ramp_tick),
      .drv_o       (drv[gi]),
      .busy_o      (ch_busy[gi])
    );
  end

  assign left_drv  = drv[0];
  assign right_drv = drv[1];
  assign busy      = |ch_busy;

endmodule
